lane_dispatch: RTL and testbench
================================

Name: lane_dispatch

Overview:
- Sequences the three output serializer lanes (A/B/C) in the 48 MHz domain.
- Pulls bytes from the dual-clock frame buffer and loads each byte into serializer lane(s) according to MODE, gated by each lane's DONE.
- Sits between the buffer read port and the three serializers, and drives the frame VALID flag.
- WR_PTR arrives already synchronized into this domain.

Parameters:
- AW, 10, buffer address width (depth 2^AW bytes).
- DW, 8, byte width.

Ports:
- CLK_48MHZ  in  1  sole clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- EN  in  1  dispatch enable, level.
- MODE  in  2  lane mapping: 00 broadcast, 01 round-robin A-B-C, 10 A only, 11 alternate A-B.
- WR_PTR  in  AW+1  buffer write pointer (binary, extra wrap bit), synchronized.
- RD_EN  out  1  buffer read strobe.
- RD_ADDR  out  AW  buffer read address.
- RD_DATA  in  DW  buffer data, valid the cycle after RD_EN.
- RD_PTR  out  AW+1  buffer read pointer (binary, extra wrap bit).
- EMPTY  out  1  RD_PTR == WR_PTR, combinational.
- DONE_A, DONE_B, DONE_C  in  1 each  lane idle/ready, level.
- LOAD_A, LOAD_B, LOAD_C  out  1 each  one-cycle load pulse to lane.
- DATA_A, DATA_B, DATA_C  out  DW each  byte presented to lane; held after LOAD.
- VALID  out  1  frame-active flag.

Behaviour:
- Reset (RSTN low, asynchronous):
  - State IDLE; RD_PTR=0; RD_EN=0; RD_ADDR=0.
  - LOAD_x=0; DATA_x=0; VALID=0.
  - Hold register=0; lane pointer=A; latched mode=00.
- Reset asserted mid-transfer aborts immediately; the byte in flight is lost and RD_PTR returns to 0.
- States and transitions:
  - IDLE: latch MODE. If the latched value differs from the previous latched mode, set lane pointer to A. If EN && !EMPTY, go to FETCH.
  - FETCH: RD_EN=1 and RD_ADDR=RD_PTR[AW-1:0] for exactly one cycle, then go to CAPTURE.
  - CAPTURE: hold register <= RD_DATA; RD_PTR <= RD_PTR+1 (wraps modulo 2^(AW+1)). Go to ISSUE.
  - ISSUE: wait until the target lane(s) have DONE high. In that cycle, pulse the target LOAD_x and drive DATA_x=hold register.
    - Then go to FETCH if EN && !EMPTY, else to IDLE.
- Targets by latched mode:
  - 00: A, B and C together; ISSUE waits for all three DONE.
  - 01: lane pointer; pointer advances A->B->C->A after each LOAD.
  - 10: A only.
  - 11: lane pointer limited to A/B; toggles after each LOAD.
- Lane pointer persists across IDLE when the mode is unchanged.
- Minimum 3 cycles per byte.
- Lanes must deassert DONE within 1 cycle of LOAD. The FETCH+CAPTURE gap guarantees no double-load of the same lane.
- MODE changes outside IDLE are ignored until the next IDLE.
- EN deasserted mid-byte: the current byte completes through ISSUE, then the block returns to IDLE. No byte is dropped or duplicated.
- EMPTY is evaluated in IDLE and ISSUE only. If a write arrives in the same cycle as the empty check, it is picked up on the next check.
- Full/wrap:
  - Occupancy = WR_PTR-RD_PTR modulo 2^(AW+1).
  - This block never reads when EMPTY. Overflow prevention is the writer's responsibility.
  - RD_ADDR wraps 1023->0 with the wrap bit toggling.
- VALID:
  - Registered; set in the cycle of the first LOAD after IDLE.
  - Cleared in the cycle after the block is in IDLE with EMPTY high and DONE_A, DONE_B and DONE_C all high.
  - Stays high across back-to-back frames.
- DATA_x of non-target lanes hold their previous value; LOAD_x of non-target lanes stays 0.

Test Plan:
- MODE=01, WR_PTR 0->3, buffer bytes 0x11,0x22,0x33, all DONE high -> LOAD_A with DATA_A=0x11, LOAD_B with 0x22, LOAD_C with 0x33, issued 3 cycles apart; RD_PTR=3; VALID 1 from first LOAD; EMPTY=1 after third CAPTURE.
- MODE=00, one byte 0xA5, DONE_C low for 10 cycles -> LOAD_A/B/C pulse together exactly once, in the cycle DONE_C rises, all DATA_x=0xA5.
- MODE=10, RD_PTR=WR_PTR=1023 wrap-bit 0, write 2 bytes (WR_PTR=0x401) -> reads at addresses 1023 then 0; RD_PTR=0x401; only LOAD_A pulses.
- MODE=11, 4 bytes; EN dropped during the second FETCH -> second byte loaded to B, then IDLE with RD_PTR=2. EN re-raised -> third byte goes to A (pointer retained).
- MODE changed 01->10 during ISSUE -> remaining bytes of the run still round-robin; after IDLE the next byte goes to A only.
- RSTN pulsed low during CAPTURE -> all outputs 0 asynchronously, RD_PTR=0, VALID=0, no LOAD pulse after release until EN && !EMPTY.

Source files
------------

// File: rtl/lane_dispatch.sv
// lane_dispatch: pulls bytes from the frame buffer read port and loads them into
// serializer lanes A/B/C according to the latched lane-mapping mode.
// One byte takes FETCH -> CAPTURE -> ISSUE, so each byte needs at least 3 cycles.
// LOAD_x, DATA_x and VALID are registered. They change on the clock edge that
// samples the target lanes' DONE high while in ISSUE.
module lane_dispatch #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          CLK_48MHZ,
  input  logic          RSTN,
  input  logic          EN,
  input  logic [1:0]    MODE,
  input  logic [AW:0]   WR_PTR,
  output logic          RD_EN,
  output logic [AW-1:0] RD_ADDR,
  input  logic [DW-1:0] RD_DATA,
  output logic [AW:0]   RD_PTR,
  output logic          EMPTY,
  input  logic          DONE_A,
  input  logic          DONE_B,
  input  logic          DONE_C,
  output logic          LOAD_A,
  output logic          LOAD_B,
  output logic          LOAD_C,
  output logic [DW-1:0] DATA_A,
  output logic [DW-1:0] DATA_B,
  output logic [DW-1:0] DATA_C,
  output logic          VALID
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned NL = 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ISSUE   = 2'd3;

  localparam logic [1:0] MODE_BCAST  = 2'b00;
  localparam logic [1:0] MODE_RR     = 2'b01;
  localparam logic [1:0] MODE_A_ONLY = 2'b10;
  localparam logic [1:0] MODE_AB     = 2'b11;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;

  localparam logic [NL-1:0] MASK_A   = 3'b001;
  localparam logic [NL-1:0] MASK_B   = 3'b010;
  localparam logic [NL-1:0] MASK_C   = 3'b100;
  localparam logic [NL-1:0] MASK_ALL = 3'b111;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          w_issue;
  logic          w_lanes_ready;
  logic [NL-1:0] w_done;
  logic [NL-1:0] w_target;
  logic [1:0]    w_ptr_next;

  logic [1:0]    r_mode;
  logic [1:0]    r_lane_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_hold;
  logic [NL-1:0] r_load;
  logic [DW-1:0] r_data_a;
  logic [DW-1:0] r_data_b;
  logic [DW-1:0] r_data_c;
  logic          r_valid;

  assign w_done = {DONE_C, DONE_B, DONE_A};
  assign EMPTY  = (r_rd_ptr == WR_PTR);

  // Lanes that the current byte goes to, based on the mode latched in IDLE.
  always_comb begin
    w_target = MASK_A;
    case (r_mode)
      MODE_BCAST:  w_target = MASK_ALL;
      MODE_A_ONLY: w_target = MASK_A;
      MODE_RR,
      MODE_AB: begin
        case (r_lane_ptr)
          LANE_A:  w_target = MASK_A;
          LANE_B:  w_target = MASK_B;
          LANE_C:  w_target = MASK_C;
          default: w_target = MASK_A;
        endcase
      end
      default:     w_target = MASK_A;
    endcase
  end

  assign w_lanes_ready = ((w_done & w_target) == w_target);

  // Lane pointer after a load: round-robin A->B->C, alternate A<->B, fixed otherwise.
  always_comb begin
    w_ptr_next = r_lane_ptr;
    case (r_mode)
      MODE_RR: begin
        case (r_lane_ptr)
          LANE_A:  w_ptr_next = LANE_B;
          LANE_B:  w_ptr_next = LANE_C;
          default: w_ptr_next = LANE_A;
        endcase
      end
      MODE_AB:     w_ptr_next = (r_lane_ptr == LANE_A) ? LANE_B : LANE_A;
      default:     w_ptr_next = r_lane_ptr;
    endcase
  end

  // Next-state logic; w_issue marks the cycle in which the target lanes get loaded.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EN && !EMPTY) w_next_state = S_FETCH;
      end
      S_FETCH:   w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_ISSUE;
      S_ISSUE: begin
        if (w_lanes_ready) begin
          w_issue      = 1'b1;
          w_next_state = (EN && !EMPTY) ? S_FETCH : S_IDLE;
        end
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_48MHZ or negedge RSTN) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Mode is sampled only in IDLE. A mode change sends the lane pointer back to A.
  always_ff @(posedge CLK_48MHZ or negedge RSTN) begin
    if (!RSTN) begin
      r_mode     <= MODE_BCAST;
      r_lane_ptr <= LANE_A;
    end else if (r_state == S_IDLE) begin
      r_mode <= MODE;
      if (MODE != r_mode) r_lane_ptr <= LANE_A;
    end else if (w_issue) begin
      r_lane_ptr <= w_ptr_next;
    end
  end

  // Buffer read port: a one-cycle strobe in FETCH, then capture and advance in CAPTURE.
  always_ff @(posedge CLK_48MHZ or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_ptr  <= '0;
      r_hold    <= '0;
    end else begin
      r_rd_en <= (w_next_state == S_FETCH);
      if (w_next_state == S_FETCH) r_rd_addr <= r_rd_ptr[AW-1:0];
      if (r_state == S_CAPTURE) begin
        r_hold   <= RD_DATA;
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Lane load pulses and held lane data; non-target lanes keep their byte.
  always_ff @(posedge CLK_48MHZ or negedge RSTN) begin
    if (!RSTN) begin
      r_load   <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
      r_data_c <= '0;
    end else begin
      r_load <= w_issue ? w_target : '0;
      if (w_issue && w_target[0]) r_data_a <= r_hold;
      if (w_issue && w_target[1]) r_data_b <= r_hold;
      if (w_issue && w_target[2]) r_data_c <= r_hold;
    end
  end

  // Frame-active flag. It rises with the first load and drops once the block is drained and all lanes are idle.
  always_ff @(posedge CLK_48MHZ or negedge RSTN) begin
    if (!RSTN) begin
      r_valid <= 1'b0;
    end else if (w_issue) begin
      r_valid <= 1'b1;
    end else if ((r_state == S_IDLE) && EMPTY && (&w_done)) begin
      r_valid <= 1'b0;
    end
  end

  assign RD_EN   = r_rd_en;
  assign RD_ADDR = r_rd_addr;
  assign RD_PTR  = r_rd_ptr;
  assign LOAD_A  = r_load[0];
  assign LOAD_B  = r_load[1];
  assign LOAD_C  = r_load[2];
  assign DATA_A  = r_data_a;
  assign DATA_B  = r_data_b;
  assign DATA_C  = r_data_c;
  assign VALID   = r_valid;

endmodule

// File: tb/tb_lane_dispatch.sv
// Self-checking bench for lane_dispatch. It models the frame buffer, and a
// scoreboard queue holds the expected {lane mask, byte} for every load.
`timescale 1ns/1ps
module tb_lane_dispatch;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic [1:0]    mode;
  logic [AW:0]   wr_ptr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          done_a, done_b, done_c;
  logic          load_a, load_b, load_c;
  logic [DW-1:0] data_a, data_b, data_c;
  logic          valid;

  typedef struct packed {
    logic [2:0]    mask;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] data;
    logic [2:0]    mask;
  } vec_t;

  exp_t          q[$];
  int unsigned   load_log[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] mem [1 << AW];
  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_err = 0;
  exp_t          mon_e;
  vec_t          vecs[12];

  always #5 clk = ~clk;

  lane_dispatch #(.AW(AW), .DW(DW)) dut (
    .CLK_48MHZ(clk), .RSTN(rstn), .EN(en), .MODE(mode), .WR_PTR(wr_ptr),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_PTR(rd_ptr),
    .EMPTY(empty), .DONE_A(done_a), .DONE_B(done_b), .DONE_C(done_c),
    .LOAD_A(load_a), .LOAD_B(load_b), .LOAD_C(load_c),
    .DATA_A(data_a), .DATA_B(data_b), .DATA_C(data_c), .VALID(valid)
  );

  // Buffer model: the data is valid in the cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: log read addresses and compare every load with the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_en) addr_log.push_back(rd_addr);
      if ({load_c, load_b, load_a} != 3'b000) begin
        load_log.push_back(cyc);
        chk("valid_at_load", 32'(valid), 32'd1);
        if (q.size() == 0) begin
          chk("unexpected_load", 32'({load_c, load_b, load_a}), 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("load_mask", 32'({load_c, load_b, load_a}), 32'(mon_e.mask));
          if (mon_e.mask[0]) chk("data_a", 32'(data_a), 32'(mon_e.data));
          if (mon_e.mask[1]) chk("data_b", 32'(data_b), 32'(mon_e.data));
          if (mon_e.mask[2]) chk("data_c", 32'(data_c), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic push(input logic [2:0] m, input logic [DW-1:0] d);
    exp_t e;
    e.mask = m;
    e.data = d;
    q.push_back(e);
  endtask

  // The writer puts a byte at WR_PTR, records where it should land, and bumps the pointer.
  task automatic wr(input logic [DW-1:0] d, input logic [2:0] m);
    mem[wr_ptr[AW-1:0]] = d;
    push(m, d);
    wr_ptr = (AW+1)'(wr_ptr + 1'b1);
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    en     = 1'b0;
    mode   = 2'b00;
    wr_ptr = '0;
    done_a = 1'b1;
    done_b = 1'b1;
    done_c = 1'b1;
    q.delete();
    load_log.delete();
    addr_log.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic drain(input string name, input int budget, input logic [AW:0] exp_ptr);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 32'(q.size()), 32'd0);
    @(negedge clk);
    chk({name, "_rd_ptr"}, 32'(rd_ptr), 32'(exp_ptr));
  endtask

  task automatic wait_fetches(input string name, input int count, input int budget);
    int n;
    int k;
    n = 0;
    k = 0;
    while (n < count && k < budget) begin
      @(negedge clk);
      k++;
      if (rd_en) n++;
    end
    chk(name, 32'(n), 32'(count));
  endtask

  initial begin
    int rise;

    // Mode, byte and expected lane(s). A change of mode restarts the lane pointer at A.
    vecs[0]  = '{2'b01, 8'h31, 3'b001};
    vecs[1]  = '{2'b01, 8'h32, 3'b010};
    vecs[2]  = '{2'b01, 8'h33, 3'b100};
    vecs[3]  = '{2'b01, 8'h34, 3'b001};
    vecs[4]  = '{2'b11, 8'h41, 3'b001};
    vecs[5]  = '{2'b11, 8'h42, 3'b010};
    vecs[6]  = '{2'b11, 8'h43, 3'b001};
    vecs[7]  = '{2'b00, 8'h51, 3'b111};
    vecs[8]  = '{2'b10, 8'h61, 3'b001};
    vecs[9]  = '{2'b10, 8'h62, 3'b001};
    vecs[10] = '{2'b01, 8'h71, 3'b001};
    vecs[11] = '{2'b01, 8'h72, 3'b010};

    // Round-robin burst, checked first for the reset state.
    do_reset();
    @(negedge clk);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_loads", 32'({load_c, load_b, load_a}), 32'd0);
    chk("rst_data", 32'({data_c, data_b, data_a}), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    mode = 2'b01;
    en   = 1'b1;
    wr(8'h11, 3'b001);
    wr(8'h22, 3'b010);
    wr(8'h33, 3'b100);
    drain("rr", 60, 11'd3);
    chk("rr_load_count", 32'(load_log.size()), 32'd3);
    if (load_log.size() >= 3) begin
      chk("rr_gap1", 32'(load_log[1] - load_log[0]), 32'd3);
      chk("rr_gap2", 32'(load_log[2] - load_log[1]), 32'd3);
    end
    chk("rr_empty", 32'(empty), 32'd1);
    repeat (3) @(negedge clk);
    chk("rr_valid_cleared", 32'(valid), 32'd0);

    // Table of single bytes, each one sent through IDLE.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      mode = vecs[i].mode;
      wr(vecs[i].data, vecs[i].mask);
      drain($sformatf("vec%0d", i), 40, (AW+1)'(i + 1));
    end

    // Broadcast waits for all three lanes; LOAD appears on the edge that samples DONE_C high.
    do_reset();
    done_c = 1'b0;
    mode   = 2'b00;
    en     = 1'b1;
    @(posedge clk); #1;
    wr(8'hA5, 3'b111);
    repeat (10) @(posedge clk);
    chk("bcast_held", 32'(load_log.size()), 32'd0);
    #1 done_c = 1'b1;
    rise = int'(cyc);
    drain("bcast", 20, 11'd1);
    chk("bcast_once", 32'(load_log.size()), 32'd1);
    if (load_log.size() >= 1) chk("bcast_timing", 32'(load_log[0]), 32'(rise + 1));

    // Address wrap: fill to 1023, then two more bytes across the wrap.
    do_reset();
    mode = 2'b10;
    en   = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1023; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      push(3'b001, 8'(i) ^ 8'h5A);
    end
    wr_ptr = 11'd1023;
    drain("fill", 3300, 11'd1023);
    addr_log.delete();
    @(posedge clk); #1;
    wr(8'hF1, 3'b001);
    wr(8'hF2, 3'b001);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'h401);
    drain("wrap", 40, 11'h401);
    chk("wrap_reads", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() >= 2) begin
      chk("wrap_addr0", 32'(addr_log[0]), 32'd1023);
      chk("wrap_addr1", 32'(addr_log[1]), 32'd0);
    end

    // Alternate A/B, with EN dropped during the second FETCH.
    do_reset();
    mode = 2'b11;
    en   = 1'b1;
    @(posedge clk); #1;
    wr(8'hD1, 3'b001);
    wr(8'hD2, 3'b010);
    wr(8'hD3, 3'b001);
    wr(8'hD4, 3'b010);
    wait_fetches("ab_second_fetch", 2, 30);
    en = 1'b0;
    repeat (8) @(negedge clk);
    chk("ab_paused_rd_ptr", 32'(rd_ptr), 32'd2);
    chk("ab_paused_pending", 32'(q.size()), 32'd2);
    @(posedge clk); #1;
    en = 1'b1;
    drain("ab_resume", 40, 11'd4);

    // A mode change during ISSUE takes effect only after the next IDLE.
    do_reset();
    mode = 2'b01;
    en   = 1'b1;
    @(posedge clk); #1;
    wr(8'hE1, 3'b001);
    wr(8'hE2, 3'b010);
    wr(8'hE3, 3'b100);
    wait_fetches("mchg_fetch", 1, 20);
    @(negedge clk);
    @(negedge clk);
    mode = 2'b10;
    drain("mchg_run", 40, 11'd3);
    @(posedge clk); #1;
    wr(8'hE4, 3'b001);
    wr(8'hE5, 3'b001);
    drain("mchg_after", 40, 11'd5);

    // Asynchronous reset during CAPTURE of the second byte.
    do_reset();
    mode = 2'b10;
    en   = 1'b1;
    @(posedge clk); #1;
    mem[0] = 8'hC0;
    mem[1] = 8'hC1;
    mem[2] = 8'hC2;
    push(3'b001, 8'hC0);
    wr_ptr = 11'd3;
    wait_fetches("rst_second_fetch", 2, 30);
    @(posedge clk); #2;
    chk("valid_before_reset", 32'(valid), 32'd1);
    rstn = 1'b0;
    en   = 1'b0;
    #1;
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_loads", 32'({load_c, load_b, load_a}), 32'd0);
    chk("arst_data", 32'({data_c, data_b, data_a}), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    q.delete();
    load_log.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_no_load", 32'(load_log.size()), 32'd0);
    chk("post_rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("post_rst_valid", 32'(valid), 32'd0);
    push(3'b001, 8'hC0);
    push(3'b001, 8'hC1);
    push(3'b001, 8'hC2);
    @(posedge clk); #1;
    en = 1'b1;
    drain("rst_resume", 40, 11'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    rstn = 1'b0;
    #500us;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule
